// File: rtl/simon_sequencer_if.sv
// Random-value control channel between the Simon random producer
// and the sequencer: a one-cycle ready strobe qualifying a 2-bit colour.
interface controls_if;
   logic       ready;
   logic [1:0] value;

   modport producer (output ready, output value);
   modport consumer (input ready, input value);
endinterface

// File: rtl/simon_sequencer.sv
// Simon sequence store, LED playback and player check.
// Optional input timeout enabled by defining SIMON_SEQ_TIMEOUT_EN.
module simon_sequencer #(
   parameter int MAX_LEN        = 32,
   parameter int ON_CYCLES      = 4,
   parameter int OFF_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                         clk,
   input  logic                         rst,
   controls_if.consumer                 ctrl,
   input  logic                         start_round,
   input  logic                         btn_valid,
   input  logic [1:0]                   btn_value,
   output logic [3:0]                   led,
   output logic                         busy,
   output logic                         awaiting_input,
   output logic                         round_ok,
   output logic                         round_fail,
   output logic [$clog2(MAX_LEN+1)-1:0] seq_len,
   output logic                         full
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int IW = $clog2(MAX_LEN);
`ifdef SIMON_SEQ_TIMEOUT_EN
   localparam int TMAX0 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
`else
   localparam int TMAX  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
`endif
   localparam int TW = $clog2(TMAX + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_RAND = 3'd1;
   localparam logic [2:0] S_SHOW_ON   = 3'd2;
   localparam logic [2:0] S_SHOW_OFF  = 3'd3;
   localparam logic [2:0] S_INPUT     = 3'd4;

   generate
      if (TIMEOUT_CYCLES < 1 || ON_CYCLES < 1 || OFF_CYCLES < 1 || MAX_LEN < 2) begin : g_bad_cfg
         $error("simon_sequencer: illegal parameter set");
      end
   endgenerate

   logic [2:0]    state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] idx_q, idx_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          ok_q, ok_d;
   logic          fail_q, fail_d;
   logic          wr_en;
   logic [1:0]    mem_q [MAX_LEN];
   logic [1:0]    cur;
   logic [LW-1:0] idx_nxt;

   assign cur     = mem_q[idx_q[IW-1:0]];
   assign idx_nxt = idx_q + LW'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q;
      ok_d    = 1'b0;
      fail_d  = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_round) begin
               idx_d   = '0;
               tmr_d   = '0;
               state_d = full ? S_SHOW_ON : S_WAIT_RAND;
            end
         end
         S_WAIT_RAND: begin
            if (ctrl.ready) begin
               wr_en   = 1'b1;
               len_d   = len_q + LW'(1);
               idx_d   = '0;
               tmr_d   = '0;
               state_d = S_SHOW_ON;
            end
         end
         S_SHOW_ON: begin
            if (tmr_q == TW'(ON_CYCLES - 1)) begin
               tmr_d   = '0;
               state_d = S_SHOW_OFF;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_SHOW_OFF: begin
            if (tmr_q == TW'(OFF_CYCLES - 1)) begin
               tmr_d = '0;
               if (idx_nxt == len_q) begin
                  idx_d   = '0;
                  state_d = S_INPUT;
               end else begin
                  idx_d   = idx_nxt;
                  state_d = S_SHOW_ON;
               end
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_INPUT: begin
            if (btn_valid) begin
               tmr_d = '0;
               if (btn_value != cur) begin
                  fail_d  = 1'b1;
                  len_d   = '0;
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else if (idx_nxt == len_q) begin
                  ok_d    = 1'b1;
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_nxt;
               end
`ifdef SIMON_SEQ_TIMEOUT_EN
            end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
               // player went quiet: treat like a wrong press
               tmr_d   = '0;
               fail_d  = 1'b1;
               len_d   = '0;
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + TW'(1);
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            tmr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         tmr_q   <= '0;
         ok_q    <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         ok_q    <= ok_d;
         fail_q  <= fail_d;
      end
   end

   // sequence contents survive reset and failure; only the length is cleared
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[len_q[IW-1:0]] <= ctrl.value;
      end
   end

   assign led            = (state_q == S_SHOW_ON) ? (4'b0001 << cur) : 4'b0000;
   assign busy           = (state_q != S_IDLE);
   assign awaiting_input = (state_q == S_INPUT);
   assign round_ok       = ok_q;
   assign round_fail     = fail_q;
   assign seq_len        = len_q;
   assign full           = (len_q == LW'(MAX_LEN));

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with MAX_LEN=4, ON=3, OFF=2.
// Timeout scenario runs only when SIMON_SEQ_TIMEOUT_EN is defined.
module tb_simon_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_round;
   logic       btn_valid;
   logic [1:0] btn_value;
   logic [3:0] led;
   logic       busy;
   logic       awaiting_input;
   logic       round_ok;
   logic       round_fail;
   logic [2:0] seq_len;
   logic       full;

   int n_chk  = 0;
   int n_fail = 0;

   logic [1:0] model [$];

   controls_if ctrl_if ();

   simon_sequencer #(
      .MAX_LEN        (4),
      .ON_CYCLES      (3),
      .OFF_CYCLES     (2),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ctrl           (ctrl_if),
      .start_round    (start_round),
      .btn_valid      (btn_valid),
      .btn_value      (btn_value),
      .led            (led),
      .busy           (busy),
      .awaiting_input (awaiting_input),
      .round_ok       (round_ok),
      .round_fail     (round_fail),
      .seq_len        (seq_len),
      .full           (full)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_led"}, led, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_await"}, awaiting_input, 0);
      chk({tag, "_ok"}, round_ok, 0);
      chk({tag, "_fail"}, round_fail, 0);
      chk({tag, "_len"}, seq_len, 0);
      chk({tag, "_full"}, full, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model.delete();
      chk_reset_outputs("reset");
   endtask

   task automatic press(input logic [1:0] v);
      btn_valid = 1'b1;
      btn_value = v;
      tick();
      btn_valid = 1'b0;
   endtask

   // replay check; noise drives every input that must be ignored during playback
   task automatic play(input bit noise);
      if (noise) begin
         start_round   = 1'b1;
         btn_valid     = 1'b1;
         ctrl_if.ready = 1'b1;
         ctrl_if.value = 2'd3;
      end
      foreach (model[i]) begin
         btn_value = model[i] + 2'd1;
         for (int c = 0; c < 3; c++) begin
            chk("led_on", led, 32'd1 << model[i]);
            tick();
         end
         for (int c = 0; c < 2; c++) begin
            chk("led_off", led, 0);
            chk("await_off", awaiting_input, 0);
            tick();
         end
      end
      start_round   = 1'b0;
      btn_valid     = 1'b0;
      ctrl_if.ready = 1'b0;
      chk("await_on", awaiting_input, 1);
      chk("led_input", led, 0);
      chk("len_play", seq_len, model.size());
   endtask

   task automatic answer_all();
      for (int i = 0; i < model.size() - 1; i++) begin
         press(model[i]);
         chk("mid_ok", round_ok, 0);
         chk("mid_await", awaiting_input, 1);
      end
      press(model[model.size() - 1]);
      chk("ok_pulse", round_ok, 1);
      chk("ok_nofail", round_fail, 0);
      chk("ok_busy", busy, 0);
      chk("ok_await", awaiting_input, 0);
      chk("ok_len", seq_len, model.size());
      tick();
      chk("ok_drop", round_ok, 0);
   endtask

   task automatic start_and_capture(input logic [1:0] v);
      start_round = 1'b1;
      tick();
      start_round = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_led", led, 0);
      ctrl_if.ready = 1'b1;
      ctrl_if.value = v;
      tick();
      ctrl_if.ready = 1'b0;
      ctrl_if.value = 2'd0;
      model.push_back(v);
      chk("cap_len", seq_len, model.size());
      chk("cap_full", full, model.size() == 4);
   endtask

   task automatic new_round(input logic [1:0] v);
      start_and_capture(v);
      play(1'b0);
      answer_all();
   endtask

   initial begin
      rst           = 1'b1;
      start_round   = 1'b0;
      btn_valid     = 1'b0;
      btn_value     = 2'd0;
      ctrl_if.ready = 1'b0;
      ctrl_if.value = 2'd0;
      tick();

      // single-step round
      do_reset();
      new_round(2'd2);

      // three correct rounds 1,3,0
      do_reset();
      new_round(2'd1);
      new_round(2'd3);
      new_round(2'd0);
      chk("three_len", seq_len, 3);

      // wrong second press
      do_reset();
      new_round(2'd1);
      new_round(2'd3);
      start_and_capture(2'd0);
      play(1'b0);
      press(2'd1);
      chk("fail_mid_await", awaiting_input, 1);
      chk("fail_mid_fail", round_fail, 0);
      press(2'd2);
      chk("fail_pulse", round_fail, 1);
      chk("fail_ok", round_ok, 0);
      chk("fail_len", seq_len, 0);
      chk("fail_led", led, 0);
      chk("fail_busy", busy, 0);
      tick();
      chk("fail_drop", round_fail, 0);
      model.delete();

      // fill to MAX_LEN
      new_round(2'd1);
      new_round(2'd3);
      new_round(2'd0);
      new_round(2'd2);
      chk("fill_full", full, 1);

      // ready in IDLE ignored
      ctrl_if.ready = 1'b1;
      ctrl_if.value = 2'd3;
      tick();
      ctrl_if.ready = 1'b0;
      chk("idle_rdy_len", seq_len, 4);
      chk("idle_rdy_busy", busy, 0);

      // full: replay without capture even with ready strobed
      start_round   = 1'b1;
      ctrl_if.ready = 1'b1;
      ctrl_if.value = 2'd1;
      tick();
      start_round   = 1'b0;
      ctrl_if.ready = 1'b0;
      chk("full_busy", busy, 1);
      chk("full_len", seq_len, 4);
      play(1'b1);
      ctrl_if.ready = 1'b1;
      ctrl_if.value = 2'd2;
      tick();
      ctrl_if.ready = 1'b0;
      chk("input_rdy_len", seq_len, 4);
      chk("input_rdy_await", awaiting_input, 1);
      answer_all();
      chk("full_len_after", seq_len, 4);
      chk("full_after", full, 1);

      // reset in the middle of SHOW_ON
      start_round = 1'b1;
      tick();
      start_round = 1'b0;
      chk("mid_show_led", led, 32'd1 << model[0]);
      tick();
      rst         = 1'b1;
      start_round = 1'b1;
      tick();
      rst         = 1'b0;
      start_round = 1'b0;
      model.delete();
      chk_reset_outputs("mid_rst");

`ifdef SIMON_SEQ_TIMEOUT_EN
      start_and_capture(2'd2);
      play(1'b0);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("to_wait_fail", round_fail, 0);
         chk("to_wait_await", awaiting_input, 1);
      end
      tick();
      chk("to_fail", round_fail, 1);
      chk("to_len", seq_len, 0);
      chk("to_busy", busy, 0);
      tick();
      chk("to_drop", round_fail, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
